// File: rtl/thermal_pkg.sv
// thermal_pkg: shared types, default thresholds and the channel-tag width
// helper for the multi-channel thermal monitor.
package thermal_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    ALARM  = 2'd1,
    TRIP   = 2'd2
  } ch_state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_NCH           = 4;
  localparam int DEF_MIN_TEMP      = 100;
  localparam int DEF_ALARM_TEMP    = 200;
  localparam int DEF_SHUTDOWN_TEMP = 250;
  localparam int DEF_HYST          = 10;
  localparam int DEF_DEBOUNCE      = 3;

  // Channel tag width; a single channel still gets a 1-bit tag.
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/thermal_channel_fsm.sv
// thermal_channel_fsm: per-channel debounce counters, NORMAL/ALARM/TRIP
// state, last-sample register and (with THERMAL_PEAK_HOLD_EN) running peak.
//
// state  | meaning
// NORMAL | no condition, alarm low
// ALARM  | DEBOUNCE consecutive samples >= ALARM_TEMP seen; exits below ALARM_TEMP-HYST
// TRIP   | DEBOUNCE consecutive samples >= SHUTDOWN_TEMP seen; latched until cleared
//
// i_sample_data arrives already range-gated (below MIN_TEMP reads as 0), so
// threshold compares and the peak need no knowledge of MIN_TEMP.
module thermal_channel_fsm
  import thermal_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int ALARM_TEMP    = DEF_ALARM_TEMP,
  parameter int SHUTDOWN_TEMP = DEF_SHUTDOWN_TEMP,
  parameter int HYST          = DEF_HYST,
  parameter int DEBOUNCE      = DEF_DEBOUNCE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_sample_en,
  input  logic [WIDTH-1:0] i_sample_data,
  input  logic             i_clear,
`ifdef THERMAL_PEAK_HOLD_EN
  output logic [WIDTH-1:0] o_peak,
`endif
  output logic             o_alarm,
  output logic             o_trip_nxt
);

  localparam logic [WIDTH-1:0] ALM_L = WIDTH'(ALARM_TEMP);
  localparam logic [WIDTH-1:0] SHD_L = WIDTH'(SHUTDOWN_TEMP);
  localparam logic [WIDTH-1:0] LO_L  = WIDTH'(ALARM_TEMP - HYST);
  localparam logic [3:0]       DB_L  = 4'(DEBOUNCE);

  ch_state_t        r_state, w_state_nxt;
  logic [3:0]       r_acnt, r_tcnt, w_acnt_nxt, w_tcnt_nxt;
  logic [WIDTH-1:0] r_last, w_last_nxt;
  logic             r_alarm;
  logic             w_trip_hit;
  logic             w_release;

  // Next-state, counter and release decode; a trip-qualifying sample beats a
  // simultaneous clear, and release looks at the previously stored sample.
  always_comb begin
    w_state_nxt = r_state;
    w_acnt_nxt  = r_acnt;
    w_tcnt_nxt  = r_tcnt;
    w_last_nxt  = r_last;
    if (i_sample_en) begin
      w_last_nxt = i_sample_data;
      if (i_sample_data >= ALM_L) w_acnt_nxt = (r_acnt >= DB_L) ? DB_L : r_acnt + 4'd1;
      else                        w_acnt_nxt = '0;
      if (i_sample_data >= SHD_L) w_tcnt_nxt = (r_tcnt >= DB_L) ? DB_L : r_tcnt + 4'd1;
      else                        w_tcnt_nxt = '0;
      case (r_state)
        NORMAL: begin
          if (w_tcnt_nxt == DB_L)      w_state_nxt = TRIP;
          else if (w_acnt_nxt == DB_L) w_state_nxt = ALARM;
        end
        ALARM: begin
          if (w_tcnt_nxt == DB_L)       w_state_nxt = TRIP;
          else if (i_sample_data < LO_L) w_state_nxt = NORMAL;
        end
        default: w_state_nxt = TRIP;
      endcase
    end
    w_trip_hit = i_sample_en && (w_tcnt_nxt == DB_L);
    w_release  = (r_state == TRIP) && i_clear && (r_last < LO_L) && !w_trip_hit;
    if (w_release) begin
      w_state_nxt = NORMAL;
      w_acnt_nxt  = '0;
      w_tcnt_nxt  = '0;
    end
  end

  // State, counters, last sample and registered alarm flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= NORMAL;
      r_acnt  <= '0;
      r_tcnt  <= '0;
      r_last  <= '0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acnt  <= w_acnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_last  <= w_last_nxt;
      r_alarm <= (w_state_nxt == ALARM);
    end
  end

  assign o_alarm    = r_alarm;
  assign o_trip_nxt = (w_state_nxt == TRIP);

`ifdef THERMAL_PEAK_HOLD_EN
  logic [WIDTH-1:0] r_peak, w_peak_nxt;

  // Running maximum; gated zeros never raise it, release wipes it.
  always_comb begin
    w_peak_nxt = r_peak;
    if (i_sample_en && (i_sample_data > r_peak)) w_peak_nxt = i_sample_data;
    if (w_release) w_peak_nxt = '0;
  end

  // Peak register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_peak <= '0;
    else     r_peak <= w_peak_nxt;
  end

  assign o_peak = r_peak;
`endif

endmodule

// File: rtl/thermal_monitor_mc.sv
// thermal_monitor_mc: multi-channel thermal monitor. Decodes tagged ADC
// samples, range-gates them, runs one thermal_channel_fsm per channel and
// registers the reported sample, alarm vector and global latched shutdown.
// Optional: THERMAL_PEAK_HOLD_EN adds peak_sel/peak_temp per-channel peak readout.
module thermal_monitor_mc
  import thermal_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int NCH           = DEF_NCH,
  parameter int MIN_TEMP      = DEF_MIN_TEMP,
  parameter int ALARM_TEMP    = DEF_ALARM_TEMP,
  parameter int SHUTDOWN_TEMP = DEF_SHUTDOWN_TEMP,
  parameter int HYST          = DEF_HYST,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  localparam int CH_W         = ch_width(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [CH_W-1:0]  sample_ch,
  input  logic [WIDTH-1:0] sample_data,
  input  logic             clear_shutdown,
`ifdef THERMAL_PEAK_HOLD_EN
  input  logic [CH_W-1:0]  peak_sel,
  output logic [WIDTH-1:0] peak_temp,
`endif
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [WIDTH-1:0] out_temp,
  output logic [NCH-1:0]   alarm,
  output logic             shutdown
);

  if (!(MIN_TEMP < ALARM_TEMP && ALARM_TEMP < SHUTDOWN_TEMP)) begin : g_bad_order
    $error("thermal_monitor_mc: need MIN_TEMP < ALARM_TEMP < SHUTDOWN_TEMP");
  end
  if (HYST < 0 || HYST > ALARM_TEMP) begin : g_bad_hyst
    $error("thermal_monitor_mc: ALARM_TEMP-HYST underflows");
  end
  if (SHUTDOWN_TEMP >= (1 << WIDTH)) begin : g_bad_width
    $error("thermal_monitor_mc: thresholds do not fit WIDTH");
  end
  if (NCH < 1 || NCH > 16 || DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_range
    $error("thermal_monitor_mc: NCH or DEBOUNCE out of range");
  end

  localparam logic [CH_W:0]    NCH_L = (CH_W+1)'(NCH);
  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_TEMP);

  logic             w_accept;
  logic [WIDTH-1:0] w_gated;
  logic [NCH-1:0]   w_ch_en;
  logic [NCH-1:0]   w_alarm;
  logic [NCH-1:0]   w_trip_nxt;
  logic             r_out_valid;
  logic [CH_W-1:0]  r_out_ch;
  logic [WIDTH-1:0] r_out_temp;
  logic             r_shutdown;

  // Tags past the last channel are dropped; the extra bit keeps the compare exact.
  assign w_accept = sample_valid && ({1'b0, sample_ch} < NCH_L);
  assign w_gated  = (sample_data >= MIN_L) ? sample_data : '0;

`ifdef THERMAL_PEAK_HOLD_EN
  logic [WIDTH-1:0] w_peak [NCH];
  logic [WIDTH-1:0] w_peak_mux;
  logic [WIDTH-1:0] r_peak_temp;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign w_ch_en[i] = w_accept && (sample_ch == CH_W'(i));
    thermal_channel_fsm #(
      .WIDTH        (WIDTH),
      .ALARM_TEMP   (ALARM_TEMP),
      .SHUTDOWN_TEMP(SHUTDOWN_TEMP),
      .HYST         (HYST),
      .DEBOUNCE     (DEBOUNCE)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_sample_en  (w_ch_en[i]),
      .i_sample_data(w_gated),
      .i_clear      (clear_shutdown),
`ifdef THERMAL_PEAK_HOLD_EN
      .o_peak       (w_peak[i]),
`endif
      .o_alarm      (w_alarm[i]),
      .o_trip_nxt   (w_trip_nxt[i])
    );
  end

  // Output stage; shutdown registers the channels' next TRIP so it lines up with out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_temp  <= '0;
      r_shutdown  <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_ch   <= sample_ch;
        r_out_temp <= w_gated;
      end
      r_shutdown <= |w_trip_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_temp  = r_out_temp;
  assign alarm     = w_alarm;
  assign shutdown  = r_shutdown;

`ifdef THERMAL_PEAK_HOLD_EN
  // Select the requested channel's peak; unused tags read as 0.
  always_comb begin
    w_peak_mux = '0;
    for (int k = 0; k < NCH; k++) begin
      if (peak_sel == CH_W'(k)) w_peak_mux = w_peak[k];
    end
  end

  // Registered peak readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_peak_temp <= '0;
    else     r_peak_temp <= w_peak_mux;
  end

  assign peak_temp = r_peak_temp;
`endif

endmodule

// File: doc/thermal_monitor_mc.md
Name: thermal_monitor_mc

Overview:
- Multi-channel successor to the single-ADC temperature controller.
- Accepts time-multiplexed ADC samples tagged with a channel number. Per channel: range-gates, debounces and classifies each sample into NORMAL / ALARM / TRIP.
- Drives per-channel alarm flags and a global latched shutdown.
- Sits between the ADC sequencer and the system power/fan controller.

Parameters:
- WIDTH, 8, ADC sample width in bits
- NCH, 4, number of monitored channels (1..16)
- MIN_TEMP, 100, lowest valid reading; below this the sample is reported as 0
- ALARM_TEMP, 200, alarm entry threshold (inclusive)
- SHUTDOWN_TEMP, 250, trip threshold (inclusive)
- HYST, 10, hysteresis subtracted from ALARM_TEMP for alarm exit and clear qualification
- DEBOUNCE, 3, consecutive qualifying samples needed to enter ALARM or TRIP (1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sample_valid  in  1  sample_ch/sample_data valid this cycle
- sample_ch  in  CH_W=$clog2(NCH) (min 1)  channel tag
- sample_data  in  WIDTH  ADC reading (unsigned)
- clear_shutdown  in  1  request to release latched trips
- out_valid  out  1  one-cycle pulse per accepted sample
- out_ch  out  CH_W  channel of reported sample
- out_temp  out  WIDTH  sample if >= MIN_TEMP, else 0
- alarm  out  NCH  per-channel alarm, bit i = channel i
- shutdown  out  1  OR of all channel TRIP states (registered)

Behaviour:
- Reset (async): out_valid=0, out_ch=0, out_temp=0, alarm=0, shutdown=0, all channels in NORMAL, debounce counters=0, last-sample registers=0.
- Acceptance: a sample is accepted when sample_valid=1 and sample_ch < NCH. Samples with sample_ch >= NCH are ignored: no out_valid, no state change.
- Latency: out_valid/out_ch/out_temp are registered 1 cycle after acceptance. alarm/shutdown reflect the sample in the same cycle as its out_valid.
- Per-channel state is touched only by samples carrying that channel's tag.
- Counters:
  - acnt increments on samples >= ALARM_TEMP, resets to 0 otherwise; saturates at DEBOUNCE.
  - tcnt increments on samples >= SHUTDOWN_TEMP, resets to 0 otherwise; saturates at DEBOUNCE.
- NORMAL -> ALARM when the updated acnt reaches DEBOUNCE.
- NORMAL or ALARM -> TRIP when the updated tcnt reaches DEBOUNCE. TRIP has priority over ALARM.
- ALARM -> NORMAL immediately on any sample < ALARM_TEMP-HYST. Samples in [ALARM_TEMP-HYST, ALARM_TEMP) hold ALARM.
- TRIP is latched, independent of later samples.
- TRIP -> NORMAL only when clear_shutdown=1 and the channel's last accepted sample < ALARM_TEMP-HYST. Counters are zeroed on exit. Channels not meeting the condition stay in TRIP.
- Simultaneous clear_shutdown and a trip-qualifying sample on the same channel in the same cycle: TRIP wins.
- alarm[i] = 1 only in ALARM. It is forced to 0 in TRIP.
- Threshold compare arithmetic is WIDTH-bit unsigned. ALARM_TEMP-HYST must not underflow; an elaboration-time check enforces this, plus MIN_TEMP < ALARM_TEMP < SHUTDOWN_TEMP.
- Reset mid-operation: every state returns to reset values within the same cycle, including latched trips.

Optional Feature:
- Macro THERMAL_PEAK_HOLD_EN.
- When defined:
  - Adds ports peak_sel (in, CH_W) and peak_temp (out, WIDTH).
  - Each channel keeps a running maximum of accepted samples >= MIN_TEMP; reset value 0.
  - peak_temp is the registered peak of channel peak_sel, 1 cycle latency.
  - A channel's peak clears when that channel leaves TRIP via clear_shutdown.
- When undefined: the ports and registers are absent, and all other behaviour is identical.

Decomposition:
- Package thermal_pkg:
  - channel state enum {NORMAL, ALARM, TRIP}
  - default threshold constants
  - function computing CH_W from NCH
- Sub-module thermal_channel_fsm, instantiated NCH times via generate:
  - Contains the debounce counters, state register, last-sample register and optional peak register.
  - Top level does acceptance decode, the output register stage and the shutdown OR.

Test Plan:
- Reset: assert rst mid-stream with ch1 in TRIP -> all outputs 0, ch1 NORMAL, shutdown=0 before the next clk edge.
- Range gate: ch0 samples 50, then 120 -> out_temp 0 then 120, out_ch=0, out_valid 1-cycle pulses, alarm=0.
- Debounce and hysteresis (ch2):
  - 210, 210, 195, 210, 210, 210 -> alarm[2] rises only after the 6th sample.
  - Then 195 -> alarm stays 1.
  - Then 185 -> alarm[2]=0.
- Trip latch (ch3):
  - 255 x3 -> shutdown=1, alarm[3]=0.
  - clear_shutdown with last sample 255 -> ignored.
  - Sample 150, then clear_shutdown -> shutdown=0.
- Interleave and priority:
  - ch0 220 and ch1 100 alternating x3 -> alarm=4'b0001.
  - sample_ch=5 with NCH=4 -> no out_valid, no state change.
  - clear_shutdown coincident with the 3rd qualifying trip sample -> shutdown=1.
- THERMAL_PEAK_HOLD_EN: ch1 samples 120, 240, 130; peak_sel=1 -> peak_temp=240. After trip clear -> 0.
